// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register read/write request (req_*) into i2c_master commands (m_*) with ACK/status checks, arbitration retry, watchdog and one response (rsp_*)
module i2c_reg_seq #(
    parameter int RETRIES   = 2,
    parameter int TO_W      = 16,
    parameter int TO_CYCLES = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [4:0] m_cmd,
    output logic       m_ws,
    output logic [7:0] m_dat,
    input  logic [3:0] m_stat,
    input  logic [7:0] m_dat_in
);
    localparam int RW = $clog2(RETRIES + 2);
    typedef enum logic [2:0] {IDLE, ISSUE, NSTOP, HOLD, WAIT, CHECK, RESP} state_t;
    state_t state, state_n;
    logic [2:0] step, step_n;
    logic [RW-1:0] retry, retry_n;
    logic [TO_W-1:0] wd, wd_n;
    logic stop_ph, stop_ph_n, rd, rd_n;
    logic [6:0] dev, dev_n;
    logic [7:0] regi, regi_n, wdata, wdata_n, dat_n, rdata_n;
    logic [4:0] cmd_n;
    logic [1:0] err_n;
    logic last, timeout;
    always_comb begin
        state_n   = state;
        step_n    = step;
        retry_n   = retry;
        wd_n      = wd;
        stop_ph_n = stop_ph;
        rd_n      = rd;
        dev_n     = dev;
        regi_n    = regi;
        wdata_n   = wdata;
        err_n     = rsp_err;
        rdata_n   = rsp_rdata;
        last      = step == (rd ? 3'd4 : 3'd3);
        timeout   = wd >= TO_W'(TO_CYCLES - 1);
        case (state)
            IDLE: if (req_valid) begin
                state_n   = ISSUE;
                step_n    = 3'd0;
                retry_n   = '0;
                stop_ph_n = 1'b0;
                rd_n      = req_rd;
                dev_n     = req_dev;
                regi_n    = req_reg;
                wdata_n   = req_wdata;
                err_n     = 2'b00;
                rdata_n   = 8'h00;
            end
            ISSUE, NSTOP: begin
                state_n = HOLD;
                wd_n    = '0;
            end
            HOLD: begin
                state_n = WAIT;
                wd_n    = wd + 1'b1;
            end
            WAIT: begin
                wd_n = wd + 1'b1;
                if (m_stat[0] && timeout) begin
                    err_n   = 2'b11;
                    state_n = RESP;
                end else if (!m_stat[0])
                    state_n = stop_ph ? RESP : CHECK;
            end
            CHECK:
                if (step == 3'd0) begin
                    step_n  = 3'd1;
                    state_n = ISSUE;
                end else if (m_stat[2]) begin
                    if (retry < RW'(RETRIES)) begin
                        retry_n = retry + 1'b1;
                        step_n  = 3'd0;
                        state_n = ISSUE;
                    end else begin
                        err_n   = 2'b10;
                        state_n = RESP;
                    end
                end else if (m_stat[1]) begin
                    err_n   = 2'b11;
                    state_n = RESP;
                end else if (m_cmd[3] && !m_stat[3]) begin
                    err_n     = 2'b01;
                    stop_ph_n = 1'b1;
                    state_n   = NSTOP;
                end else if (last) begin
                    rdata_n = rd ? m_dat_in : 8'h00;
                    err_n   = 2'b00;
                    state_n = RESP;
                end else begin
                    step_n  = step + 3'd1;
                    state_n = ISSUE;
                end
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cmd_n = state_n == NSTOP ? 5'b00010 : state_n != ISSUE ? m_cmd :
                step_n == 3'd1 ? 5'b01001 : step_n == 3'd2 ? 5'b01000 :
                step_n == 3'd3 ? (rd_n ? 5'b01001 : 5'b01010) :
                step_n == 3'd4 ? 5'b10110 : 5'b00000;
        dat_n = state_n != ISSUE ? m_dat :
                step_n == 3'd1 ? {dev_n, 1'b0} : step_n == 3'd2 ? regi_n :
                step_n == 3'd3 ? (rd_n ? {dev_n, 1'b1} : wdata_n) : 8'h00;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            step      <= 3'd0;
            retry     <= '0;
            wd        <= '0;
            stop_ph   <= 1'b0;
            rd        <= 1'b0;
            dev       <= 7'h00;
            regi      <= 8'h00;
            wdata     <= 8'h00;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 2'b00;
            m_cmd     <= 5'b00000;
            m_ws      <= 1'b0;
            m_dat     <= 8'h00;
        end else begin
            state     <= state_n;
            step      <= step_n;
            retry     <= retry_n;
            wd        <= wd_n;
            stop_ph   <= stop_ph_n;
            rd        <= rd_n;
            dev       <= dev_n;
            regi      <= regi_n;
            wdata     <= wdata_n;
            req_ready <= state_n == IDLE;
            rsp_valid <= state_n == RESP;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            m_cmd     <= cmd_n;
            m_ws      <= state_n == ISSUE || state_n == NSTOP;
            m_dat     <= dat_n;
        end
endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed bench for i2c_reg_seq against a small behavioural i2c_master model
module tb_i2c_reg_seq;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_rd = 1'b0, rsp_valid, rsp_ready = 1'b0, m_ws;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00, req_wdata = 8'h00, rsp_rdata, m_dat;
    logic [1:0] rsp_err;
    logic [4:0] m_cmd;
    logic [3:0] m_stat;
    logic [7:0] m_dat_in = 8'h3C;
    int checks = 0, errors = 0;
    int n_ws = 0, s2_cnt = 0, s2_base = 0, alo_limit = 0, busy_len = 3, bsy_cnt = 0;
    logic nack_addr = 1'b0, err_inj = 1'b0, stuck = 1'b0, ack_r = 1'b0, alo_r = 1'b0, err_r = 1'b0;
    logic [4:0] cmd_log [256];
    logic [7:0] dat_log [256];
    i2c_reg_seq #(.RETRIES(2), .TO_W(16), .TO_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_cmd(m_cmd),
        .m_ws(m_ws), .m_dat(m_dat), .m_stat(m_stat), .m_dat_in(m_dat_in)
    );
    always #5 clk = ~clk;
    assign m_stat = {ack_r, alo_r, err_r, bsy_cnt != 0 || stuck};
    always @(posedge clk)
        if (rst) bsy_cnt <= 0;
        else if (m_ws) begin
            cmd_log[n_ws] <= m_cmd;
            dat_log[n_ws] <= m_dat;
            n_ws    <= n_ws + 1;
            bsy_cnt <= busy_len;
            ack_r   <= m_cmd[3] && !(nack_addr && m_cmd[0]);
            alo_r   <= m_cmd == 5'b01000 && (s2_cnt - s2_base) < alo_limit;
            err_r   <= err_inj && m_cmd == 5'b01001;
            if (m_cmd == 5'b01000) s2_cnt <= s2_cnt + 1;
        end else if (bsy_cnt != 0) bsy_cnt <= bsy_cnt - 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic start_req(input logic r, input logic [6:0] d, input logic [7:0] g, input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rd = r; req_dev = d; req_reg = g; req_wdata = w;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("accept", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("ws_lat", 32'(m_ws), 1);
        check("busy_rdy", 32'(req_ready), 0);
    endtask
    task automatic wait_rsp(output logic [1:0] e, output logic [7:0] rd_o, output int n);
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        check("rsp_seen", 32'(rsp_valid), 1);
        e = rsp_err; rd_o = rsp_rdata;
        @(negedge clk);
        check("rsp_hold", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 0);
    endtask
    task automatic do_req(input logic r, input logic [6:0] d, input logic [7:0] g, input logic [7:0] w,
                          output logic [1:0] e, output logic [7:0] rd_o, output int n);
        start_req(r, d, g, w);
        wait_rsp(e, rd_o, n);
    endtask
    function automatic int clrs_count(input int b);
        int c = 0;
        for (int i = b; i < n_ws; i++) if (cmd_log[i] == 5'b00000) c++;
        return c;
    endfunction
    initial begin
        logic [1:0] e;
        logic [7:0] rdv;
        int n, b;
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_ws", 32'(m_ws), 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata, m_cmd, m_dat}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 1);
        b = n_ws;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, e, rdv, n);
        check("wr_n", n_ws - b, 4);
        check("wr_cmds", {cmd_log[b], cmd_log[b+1], cmd_log[b+2], cmd_log[b+3]},
              {5'b00000, 5'b01001, 5'b01000, 5'b01010});
        check("wr_dats", {dat_log[b+1], dat_log[b+2], dat_log[b+3]}, 32'hA010A5);
        check("wr_rsp", {e, rdv}, {2'b00, 8'h00});
        b = n_ws;
        do_req(1'b1, 7'h50, 8'h22, 8'hFF, e, rdv, n);
        check("rd_n", n_ws - b, 5);
        check("rd_cmds", {cmd_log[b], cmd_log[b+1], cmd_log[b+2], cmd_log[b+3], cmd_log[b+4]},
              {5'b00000, 5'b01001, 5'b01000, 5'b01001, 5'b10110});
        check("rd_dats", {dat_log[b+1], dat_log[b+2], dat_log[b+3]}, 32'hA022A1);
        check("rd_rsp", {e, rdv}, {2'b00, 8'h3C});
        nack_addr = 1'b1;
        b = n_ws;
        do_req(1'b0, 7'h50, 8'h10, 8'h5A, e, rdv, n);
        nack_addr = 1'b0;
        check("nack_n", n_ws - b, 3);
        check("nack_stop", 32'(cmd_log[b+2]), 32'(5'b00010));
        check("nack_rsp", {e, rdv}, {2'b01, 8'h00});
        s2_base = s2_cnt; alo_limit = 2;
        b = n_ws;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, e, rdv, n);
        check("alo2_n", n_ws - b, 10);
        check("alo2_clrs", clrs_count(b), 3);
        check("alo2_rsp", {e, rdv}, {2'b00, 8'h00});
        s2_base = s2_cnt; alo_limit = 100;
        b = n_ws;
        do_req(1'b1, 7'h50, 8'h10, 8'h00, e, rdv, n);
        alo_limit = 0;
        check("aloall_n", n_ws - b, 9);
        check("aloall_clrs", clrs_count(b), 3);
        check("aloall_rsp", {e, rdv}, {2'b10, 8'h00});
        err_inj = 1'b1;
        b = n_ws;
        do_req(1'b1, 7'h50, 8'h10, 8'h00, e, rdv, n);
        err_inj = 1'b0;
        check("merr_n", n_ws - b, 2);
        check("merr_rsp", {e, rdv}, {2'b11, 8'h00});
        stuck = 1'b1;
        b = n_ws;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, e, rdv, n);
        stuck = 1'b0;
        check("to_n", n_ws - b, 1);
        check("to_rsp", {e, rdv}, {2'b11, 8'h00});
        check("to_lat", 32'(n >= 95 && n <= 103), 1);
        busy_len = 20;
        b = n_ws;
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        n = 0;
        while (n_ws - b < 3 && n < 200) begin @(negedge clk); n++; end
        check("rst_reach_s2", n_ws - b, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_len = 3;
        @(negedge clk);
        check("midrst_out", {m_ws, rsp_valid, req_ready}, 3'b001);
        b = n_ws;
        do_req(1'b0, 7'h51, 8'h33, 8'h77, e, rdv, n);
        check("post_n", n_ws - b, 4);
        check("post_dats", {dat_log[b+1], dat_log[b+2], dat_log[b+3]}, 32'hA23377);
        check("post_rsp", {e, rdv}, {2'b00, 8'h00});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
